// File: rtl/alu_m_exec_sequencer.sv
// Multi-cycle RV32M execution controller: accepts one op from the reservation station,
// runs a radix-2 shift-add multiplier / restoring divider, and holds the result for the CDB.
module alu_m_exec_sequencer #(
  parameter int ROBSIZE = 8,
  parameter int ITER    = 32
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               i_flush,
  input  logic               i_alu_ex_en,
  input  logic [2:0]         i_alu_opcode,
  input  logic [31:0]        i_rs1_value,
  input  logic [31:0]        i_rs2_value,
  input  logic [ROBSIZE-1:0] i_rob_addr,
  output logic               o_alu_busy,
  output logic               o_cdb_req,
  input  logic               i_cdb_grant,
  output logic [ROBSIZE-1:0] o_cdb_rob_addr,
  output logic [31:0]        o_cdb_data,
  output logic [2:0]         dbg_state
);

  localparam int CW = $clog2(ITER + 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_MUL  = 3'd1,
    S_DIV  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t             state;
  logic [CW-1:0]      cnt;
  logic [2:0]         op_r;
  logic [ROBSIZE-1:0] rob_r;
  logic [31:0]        a_r, b_r;
  logic [63:0]        acc;
  logic [31:0]        rem;
  logic               neg_q, neg_r;
  logic [31:0]        data_r;
  logic [ROBSIZE-1:0] rob_out;

  // Handshake: dispatch is taken only while busy is low; the result is
  // offered while req is high and leaves on the first edge with grant high.
  assign o_alu_busy     = (state != S_IDLE);
  assign o_cdb_req      = (state == S_DONE);
  assign o_cdb_data     = data_r;
  assign o_cdb_rob_addr = rob_out;
  assign dbg_state      = state;

  logic        a_neg, b_neg, is_rem, ovf;
  logic [31:0] a_mag, b_mag;

  always_comb begin
    a_neg  = (i_alu_opcode != 3'd3) && (i_alu_opcode != 3'd5) &&
             (i_alu_opcode != 3'd7) && i_rs1_value[31];
    b_neg  = (i_alu_opcode == 3'd0 || i_alu_opcode == 3'd1 ||
              i_alu_opcode == 3'd4 || i_alu_opcode == 3'd6) && i_rs2_value[31];
    a_mag  = a_neg ? (32'd0 - i_rs1_value) : i_rs1_value;
    b_mag  = b_neg ? (32'd0 - i_rs2_value) : i_rs2_value;
    is_rem = i_alu_opcode[1];
    ovf    = (i_alu_opcode == 3'd4 || i_alu_opcode == 3'd6) &&
             (i_rs1_value == 32'h8000_0000) && (i_rs2_value == 32'hFFFF_FFFF);
  end

  // Multiplier keeps {high partial, remaining multiplier bits} in acc;
  // the divider uses acc[31:0] as dividend-in / quotient-out.
  logic [32:0] mul_sum;
  logic [32:0] shifted;
  logic        ge;
  logic [63:0] prod;
  logic [31:0] quo, remv, result;

  always_comb begin
    mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, a_r} : 33'd0);
    shifted = {rem, acc[31]};
    ge      = (shifted >= {1'b0, b_r});
    prod    = neg_q ? (64'd0 - acc) : acc;
    quo     = neg_q ? (32'd0 - acc[31:0]) : acc[31:0];
    remv    = neg_r ? (32'd0 - rem) : rem;
    case (op_r)
      3'd0:                result = prod[31:0];
      3'd1, 3'd2, 3'd3:    result = prod[63:32];
      3'd4, 3'd5:          result = quo;
      default:             result = remv;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= S_IDLE;
      cnt     <= '0;
      op_r    <= '0;
      rob_r   <= '0;
      a_r     <= '0;
      b_r     <= '0;
      acc     <= '0;
      rem     <= '0;
      neg_q   <= 1'b0;
      neg_r   <= 1'b0;
      data_r  <= '0;
      rob_out <= '0;
    end else if (i_flush) begin
      state   <= S_IDLE;
      cnt     <= '0;
      data_r  <= '0;
      rob_out <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_alu_ex_en) begin
          op_r  <= i_alu_opcode;
          rob_r <= i_rob_addr;
          a_r   <= a_mag;
          b_r   <= b_mag;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= '0;
          if (!i_alu_opcode[2]) begin
            acc   <= {32'd0, b_mag};
            state <= S_MUL;
          end else if (i_rs2_value == 32'd0) begin
            data_r  <= is_rem ? i_rs1_value : 32'hFFFF_FFFF;
            rob_out <= i_rob_addr;
            state   <= S_DONE;
          end else if (ovf) begin
            data_r  <= is_rem ? 32'd0 : 32'h8000_0000;
            rob_out <= i_rob_addr;
            state   <= S_DONE;
          end else begin
            acc   <= {32'd0, a_mag};
            rem   <= '0;
            state <= S_DIV;
          end
        end
        S_MUL: begin
          acc <= {mul_sum, acc[31:1]};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_DIV: begin
          rem       <= ge ? 32'(shifted - {1'b0, b_r}) : shifted[31:0];
          acc[31:0] <= {acc[30:0], ge};
          cnt       <= cnt + 1'b1;
          if (cnt == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          data_r  <= result;
          rob_out <= rob_r;
          cnt     <= '0;
          state   <= S_DONE;
        end
        S_DONE: if (i_cdb_grant) begin
          data_r  <= '0;
          rob_out <= '0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  a_no_dispatch_when_busy: assert property (
    @(posedge clk) disable iff (!rstn) !(i_alu_ex_en && o_alu_busy));

endmodule

// File: tb/tb_alu_m_exec_sequencer.sv
// Directed bench for alu_m_exec_sequencer: vector table for results and latency,
// plus hand sequences for reset, flush and hold corner cases.
module tb_alu_m_exec_sequencer;

  logic        clk;
  logic        rstn;
  logic        i_flush;
  logic        i_alu_ex_en;
  logic [2:0]  i_alu_opcode;
  logic [31:0] i_rs1_value;
  logic [31:0] i_rs2_value;
  logic [7:0]  i_rob_addr;
  logic        o_alu_busy;
  logic        o_cdb_req;
  logic        i_cdb_grant;
  logic [7:0]  o_cdb_rob_addr;
  logic [31:0] o_cdb_data;
  logic [2:0]  dbg_state;

  alu_m_exec_sequencer #(.ROBSIZE(8), .ITER(32)) dut (
    .clk            (clk),
    .rstn           (rstn),
    .i_flush        (i_flush),
    .i_alu_ex_en    (i_alu_ex_en),
    .i_alu_opcode   (i_alu_opcode),
    .i_rs1_value    (i_rs1_value),
    .i_rs2_value    (i_rs2_value),
    .i_rob_addr     (i_rob_addr),
    .o_alu_busy     (o_alu_busy),
    .o_cdb_req      (o_cdb_req),
    .i_cdb_grant    (i_cdb_grant),
    .o_cdb_rob_addr (o_cdb_rob_addr),
    .o_cdb_data     (o_cdb_data),
    .dbg_state      (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [7:0]  rob;
    logic [31:0] exp;
    int          lat;
    int          hold;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // driver + scoreboard for one complete op
  task automatic run_op(input vec_t v, input string name);
    logic [31:0] e;
    int n;
    i_alu_opcode = v.op;
    i_rs1_value  = v.a;
    i_rs2_value  = v.b;
    i_rob_addr   = v.rob;
    i_alu_ex_en  = 1'b1;
    exp_q.push_back(v.exp);
    tick();
    i_alu_ex_en = 1'b0;
    check({name, " busy_after_accept"}, 64'(o_alu_busy), 64'd1);
    n = 0;
    while (!o_cdb_req && n < 40) begin
      tick();
      n++;
    end
    check({name, " latency"}, 64'(n), 64'(v.lat));
    e = exp_q.pop_front();
    if (o_cdb_req) begin
      check({name, " data"}, 64'(o_cdb_data), 64'(e));
      check({name, " rob"}, 64'(o_cdb_rob_addr), 64'(v.rob));
      for (int h = 0; h < v.hold; h++) begin
        tick();
        check({name, " hold_req"}, 64'(o_cdb_req), 64'd1);
        check({name, " hold_data"}, 64'(o_cdb_data), 64'(e));
        check({name, " hold_rob"}, 64'(o_cdb_rob_addr), 64'(v.rob));
      end
    end
    i_cdb_grant = 1'b1;
    tick();
    i_cdb_grant = 1'b0;
    check({name, " idle_busy"}, 64'(o_alu_busy), 64'd0);
    check({name, " idle_data"}, 64'(o_cdb_data), 64'd0);
  endtask

  initial begin
    vec_t v;
    int   req_seen;

    vecs[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 8'd3,  32'hFFFF_FFEB, 33, 5};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 8'd11, 32'hFFFF_FFFE, 33, 0};
    vecs[2]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 8'd12, 32'h4000_0000, 33, 0};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 8'd13, 32'hFFFF_FFFF, 33, 0};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         8'd14, 32'hFFFF_FFFD, 33, 0};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         8'd15, 32'hFFFF_FFFF, 33, 0};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         8'd16, 32'd14,        33, 0};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         8'd17, 32'd2,         33, 0};
    vecs[8]  = '{3'd5, 32'h1234,       32'd0,         8'd18, 32'hFFFF_FFFF, 0,  0};
    vecs[9]  = '{3'd7, 32'h1234,       32'd0,         8'd19, 32'h1234,      0,  0};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 8'd20, 32'h8000_0000, 0,  0};
    vecs[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 8'd21, 32'd0,         0,  0};
    vecs[12] = '{3'd4, 32'd100,        32'hFFFF_FFF9, 8'd22, 32'hFFFF_FFF2, 33, 0};
    vecs[13] = '{3'd6, 32'hFFFF_FF9C,  32'd7,         8'd23, 32'hFFFF_FFFE, 33, 0};
    vecs[14] = '{3'd6, 32'hFFFF_FFFB,  32'd0,         8'd24, 32'hFFFF_FFFB, 0,  0};
    vecs[15] = '{3'd0, 32'h0001_0003,  32'h0002_0005, 8'd25, 32'h000B_000F, 33, 0};

    rstn         = 1'b0;
    i_flush      = 1'b0;
    i_alu_ex_en  = 1'b0;
    i_alu_opcode = 3'd0;
    i_rs1_value  = 32'd0;
    i_rs2_value  = 32'd0;
    i_rob_addr   = 8'd0;
    i_cdb_grant  = 1'b0;
    tick();
    tick();
    check("reset busy", 64'(o_alu_busy), 64'd0);
    check("reset req", 64'(o_cdb_req), 64'd0);
    check("reset data", 64'(o_cdb_data), 64'd0);
    check("reset rob", 64'(o_cdb_rob_addr), 64'd0);
    check("reset state", 64'(dbg_state), 64'd0);
    rstn = 1'b1;
    tick();

    // reset asserted mid-MUL, ten edges after accept
    i_alu_opcode = 3'd0;
    i_rs1_value  = 32'd9;
    i_rs2_value  = 32'd3;
    i_rob_addr   = 8'd7;
    i_alu_ex_en  = 1'b1;
    tick();
    i_alu_ex_en = 1'b0;
    repeat (9) tick();
    check("midmul busy_before_reset", 64'(o_alu_busy), 64'd1);
    #3 rstn = 1'b0;
    #1;
    check("midmul_reset busy", 64'(o_alu_busy), 64'd0);
    check("midmul_reset req", 64'(o_cdb_req), 64'd0);
    check("midmul_reset data", 64'(o_cdb_data), 64'd0);
    tick();
    rstn = 1'b1;
    tick();
    v = '{3'd0, 32'd5, 32'd6, 8'd4, 32'h0000_001E, 33, 0};
    run_op(v, "mul_after_reset");

    for (int i = 0; i < 16; i++) begin
      run_op(vecs[i], $sformatf("vec%0d", i));
    end

    // flush on edge 20 of a divide
    i_alu_opcode = 3'd5;
    i_rs1_value  = 32'd100;
    i_rs2_value  = 32'd7;
    i_rob_addr   = 8'd30;
    i_alu_ex_en  = 1'b1;
    tick();
    i_alu_ex_en = 1'b0;
    repeat (19) tick();
    i_flush = 1'b1;
    tick();
    i_flush = 1'b0;
    check("div_flush busy", 64'(o_alu_busy), 64'd0);
    req_seen = 0;
    repeat (40) begin
      tick();
      if (o_cdb_req) req_seen++;
    end
    check("div_flush no_req", 64'(req_seen), 64'd0);

    // flush coincident with grant while holding a result
    i_alu_opcode = 3'd5;
    i_rs1_value  = 32'd9;
    i_rs2_value  = 32'd0;
    i_rob_addr   = 8'd31;
    i_alu_ex_en  = 1'b1;
    tick();
    i_alu_ex_en = 1'b0;
    check("done_flush req_before", 64'(o_cdb_req), 64'd1);
    i_flush     = 1'b1;
    i_cdb_grant = 1'b1;
    tick();
    i_flush     = 1'b0;
    i_cdb_grant = 1'b0;
    check("done_flush busy", 64'(o_alu_busy), 64'd0);
    check("done_flush req", 64'(o_cdb_req), 64'd0);
    check("done_flush data", 64'(o_cdb_data), 64'd0);
    check("done_flush rob", 64'(o_cdb_rob_addr), 64'd0);

    // dispatch together with flush must not be accepted
    i_alu_opcode = 3'd5;
    i_rs1_value  = 32'h55;
    i_rs2_value  = 32'd0;
    i_rob_addr   = 8'd32;
    i_alu_ex_en  = 1'b1;
    i_flush      = 1'b1;
    tick();
    i_alu_ex_en = 1'b0;
    i_flush     = 1'b0;
    check("exen_flush busy", 64'(o_alu_busy), 64'd0);
    check("exen_flush req", 64'(o_cdb_req), 64'd0);
    tick();
    check("exen_flush busy_later", 64'(o_alu_busy), 64'd0);

    v = '{3'd7, 32'd50, 32'd8, 8'd33, 32'd2, 33, 0};
    run_op(v, "remu_after_flush");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
